// File: rtl/ucsbece154b_perf_counters_if.sv
// Control, event and readback bundle of the ucsbece154b performance-monitor block.
interface ucsbece154b_perf_counters_if #(
  parameter int NUM_CH = 6,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
);
  logic              start_i;
  logic              stop_i;
  logic              clear_i;
  logic [NUM_CH-1:0] event_i;
  logic              snap_req_i;
  logic              snap_valid_o;
  logic [SEL_W-1:0]  sel_i;
  logic [CNT_W-1:0]  count_o;
  logic [NUM_CH-1:0] overflow_o;
  logic [CNT_W-1:0]  cycles_o;
  logic              running_o;
  logic              done_o;

  modport master (
    output start_i, stop_i, clear_i, event_i, snap_req_i, sel_i,
    input  snap_valid_o, count_o, overflow_o, cycles_o, running_o, done_o
  );

  modport slave (
    input  start_i, stop_i, clear_i, event_i, snap_req_i, sel_i,
    output snap_valid_o, count_o, overflow_o, cycles_o, running_o, done_o
  );
endinterface

// File: rtl/ucsbece154b_perf_counters.sv
// Event/cycle performance counters with run/halt FSM and snapshot readback.
// Define PERF_SATURATE_EN to make all counters saturate at all-ones instead of wrapping.
module ucsbece154b_perf_counters #(
  parameter int                NUM_CH      = 6,
  parameter int                CNT_W       = 32,
  parameter int                SEL_W       = 4,
  parameter logic [NUM_CH-1:0] EDGE_MASK   = NUM_CH'(6'b000011),
  parameter int                CYCLE_LIMIT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  ucsbece154b_perf_counters_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  live   [NUM_CH];
  logic [CNT_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] qualified;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  cycles_inc;
  logic [CNT_W-1:0]  count_mux;
  logic              snap_valid;
  logic              limit_hit;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PERF_SATURATE_EN
    bump = (v == MAX_CNT) ? MAX_CNT : v + CNT_W'(1);
`else
    bump = v + CNT_W'(1);
`endif
  endfunction

  assign qualified  = (bus.event_i & ~prev & EDGE_MASK) | (bus.event_i & ~EDGE_MASK);
  assign cycles_inc = bump(cycles);
  assign limit_hit  = (CYCLE_LIMIT != 0) && (cycles_inc == CNT_W'(CYCLE_LIMIT));

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; clear overrides every transition
  always_comb begin
    state_next = state;
    if (bus.clear_i) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_next = (bus.start_i && !bus.stop_i) ? S_RUN : S_IDLE;
        S_RUN:   state_next = (bus.stop_i || limit_hit) ? S_HALT : S_RUN;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM output decode
  always_comb begin
    bus.running_o = 1'b0;
    bus.done_o    = 1'b0;
    case (state)
      S_RUN:   bus.running_o = 1'b1;
      S_HALT:  bus.done_o    = 1'b1;
      default: bus.running_o = 1'b0;
    endcase
  end

  // Edge history follows the raw lines in every state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= {NUM_CH{1'b0}};
    else        prev <= bus.event_i;
  end

  // Live event counters, cycle counter and sticky overflow flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= {CNT_W{1'b0}};
      ovf    <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) live[i] <= {CNT_W{1'b0}};
    end else if (bus.clear_i) begin
      cycles <= {CNT_W{1'b0}};
      ovf    <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) live[i] <= {CNT_W{1'b0}};
    end else if (state == S_RUN) begin
      cycles <= cycles_inc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (qualified[i]) begin
          live[i] <= bump(live[i]);
          if (live[i] == MAX_CNT) ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Shadow bank captures pre-increment values; clear beats a simultaneous snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= {CNT_W{1'b0}};
    end else begin
      snap_valid <= bus.snap_req_i;
      if (bus.clear_i) begin
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= {CNT_W{1'b0}};
      end else if (bus.snap_req_i) begin
        for (int i = 0; i < NUM_CH; i++) shadow[i] <= live[i];
      end
    end
  end

  // Readback mux; unpopulated selects read as zero
  always_comb begin
    count_mux = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      count_mux = (bus.sel_i == SEL_W'(i)) ? shadow[i] : count_mux;
    end
  end

  assign bus.count_o      = count_mux;
  assign bus.cycles_o     = cycles;
  assign bus.overflow_o   = ovf;
  assign bus.snap_valid_o = snap_valid;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Randomised and directed bench for ucsbece154b_perf_counters: a 4-bit wrapping
// instance and a 32-bit instance with a 10-cycle limit run side by side.
module tb_ucsbece154b_perf_counters;

  localparam int NCH = 6;
`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [5:0] EMASK = 6'b000011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ucsbece154b_perf_counters_if #(.NUM_CH(NCH), .CNT_W(4),  .SEL_W(4)) ifa ();
  ucsbece154b_perf_counters_if #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4)) ifb ();

  ucsbece154b_perf_counters #(.NUM_CH(NCH), .CNT_W(4), .SEL_W(4),
                              .EDGE_MASK(EMASK), .CYCLE_LIMIT(0))
    dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  ucsbece154b_perf_counters #(.NUM_CH(NCH), .CNT_W(32), .SEL_W(4),
                              .EDGE_MASK(EMASK), .CYCLE_LIMIT(10))
    dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = 4-bit wrap instance, index 1 = 32-bit limited instance
  int     m_w   [2] = '{4, 32};
  longint m_lim [2] = '{0, 10};
  longint m_live   [2][NCH];
  longint m_shadow [2][NCH];
  bit     m_ovf    [2][NCH];
  longint m_cyc    [2];
  int     m_st     [2];   // 0 idle, 1 run, 2 halt
  bit     m_snapv  [2];
  bit     m_prev   [NCH];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint maxv(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 0; m_st[d] = 0; m_snapv[d] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_live[d][c] = 0; m_shadow[d][c] = 0; m_ovf[d][c] = 1'b0;
      end
    end
    for (int c = 0; c < NCH; c++) m_prev[c] = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl,
                            input logic [5:0] ev, input bit sn);
    for (int d = 0; d < 2; d++) begin
      longint mx;
      mx = maxv(m_w[d]);
      m_snapv[d] = sn;
      if (cl) begin
        m_cyc[d] = 0; m_st[d] = 0;
        for (int c = 0; c < NCH; c++) begin
          m_live[d][c] = 0; m_shadow[d][c] = 0; m_ovf[d][c] = 1'b0;
        end
      end else begin
        if (sn) for (int c = 0; c < NCH; c++) m_shadow[d][c] = m_live[d][c];
        if (m_st[d] == 1) begin
          for (int c = 0; c < NCH; c++) begin
            bit q;
            q = EMASK[c] ? (ev[c] && !m_prev[c]) : ev[c];
            if (q) begin
              if (m_live[d][c] == mx) begin
                m_ovf[d][c]  = 1'b1;
                m_live[d][c] = SAT ? mx : 0;
              end else begin
                m_live[d][c]++;
              end
            end
          end
          if (m_cyc[d] == mx) m_cyc[d] = SAT ? mx : 0;
          else                m_cyc[d]++;
          if (sp || (m_lim[d] != 0 && m_cyc[d] == m_lim[d])) m_st[d] = 2;
        end else if (m_st[d] == 0 && st && !sp) begin
          m_st[d] = 1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) m_prev[c] = ev[c];
  endtask

  task automatic compare_all(input logic [3:0] sl);
    logic [5:0] eo_a, eo_b;
    for (int c = 0; c < NCH; c++) begin
      eo_a[c] = m_ovf[0][c];
      eo_b[c] = m_ovf[1][c];
    end
    check_eq("a_snap_valid", longint'(ifa.snap_valid_o), longint'(m_snapv[0]));
    check_eq("b_snap_valid", longint'(ifb.snap_valid_o), longint'(m_snapv[1]));
    check_eq("a_overflow",   longint'(ifa.overflow_o), longint'(eo_a));
    check_eq("b_overflow",   longint'(ifb.overflow_o), longint'(eo_b));
    check_eq("a_cycles",     longint'(ifa.cycles_o), m_cyc[0]);
    check_eq("b_cycles",     longint'(ifb.cycles_o), m_cyc[1]);
    check_eq("a_running",    longint'(ifa.running_o), longint'(m_st[0] == 1));
    check_eq("b_running",    longint'(ifb.running_o), longint'(m_st[1] == 1));
    check_eq("a_done",       longint'(ifa.done_o), longint'(m_st[0] == 2));
    check_eq("b_done",       longint'(ifb.done_o), longint'(m_st[1] == 2));
    check_eq("a_count", longint'(ifa.count_o), (sl < NCH) ? m_shadow[0][sl] : 0);
    check_eq("b_count", longint'(ifb.count_o), (sl < NCH) ? m_shadow[1][sl] : 0);
  endtask

  task automatic drive(input bit st, input bit sp, input bit cl,
                       input logic [5:0] ev, input bit sn, input logic [3:0] sl);
    ifa.start_i = st; ifa.stop_i = sp; ifa.clear_i = cl;
    ifa.event_i = ev; ifa.snap_req_i = sn; ifa.sel_i = sl;
    ifb.start_i = st; ifb.stop_i = sp; ifb.clear_i = cl;
    ifb.event_i = ev; ifb.snap_req_i = sn; ifb.sel_i = sl;
  endtask

  // One clock: apply inputs, advance model on the edge, compare at the falling edge
  task automatic cycle(input bit st, input bit sp, input bit cl,
                       input logic [5:0] ev, input bit sn, input logic [3:0] sl);
    drive(st, sp, cl, ev, sn, sl);
    @(posedge clk);
    model_step(st, sp, cl, ev, sn);
    @(negedge clk);
    compare_all(sl);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    repeat (2) @(negedge clk);
    compare_all(4'd0);
    reset = 1'b1;

    // Edge vs level: ch0 edge-mode and ch2 level-mode held high for 5 RUN cycles
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 6'b000101, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    check_eq("edge_ch0", longint'(ifa.count_o), 1);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    check_eq("level_ch2", longint'(ifa.count_o), 5);

    // Priority in HALT: clear together with snapshot
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 4'd2);
    check_eq("clr_snap_pulse", longint'(ifa.snap_valid_o), 1);
    check_eq("clr_snap_shadow", longint'(ifa.count_o), 0);
    check_eq("clr_idle", longint'(ifa.done_o), 0);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    check_eq("clr_snap_once", longint'(ifa.snap_valid_o), 0);

    // start with stop in IDLE stays IDLE
    cycle(1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 4'd0);
    check_eq("start_stop_idle", longint'(ifa.running_o), 0);

    // Cycle limit on the 32-bit instance
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      check_eq("limit_running", longint'(ifb.running_o), 1);
      cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    end
    check_eq("limit_done", longint'(ifb.done_o), 1);
    check_eq("limit_cycles", longint'(ifb.cycles_o), 10);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    check_eq("halt_ignores_start", longint'(ifb.done_o), 1);

    // Snapshot timing: request on the edge that moves ch2 from 7 to 8
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 6'b000100, 1'b0, 4'd2);
    cycle(1'b0, 1'b0, 1'b0, 6'b000100, 1'b1, 4'd2);
    check_eq("snap_pre_value", longint'(ifa.count_o), 7);
    check_eq("snap_pulse", longint'(ifa.snap_valid_o), 1);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 4'd15);
    check_eq("sel15_zero", longint'(ifa.count_o), 0);
    check_eq("snap_b2b", longint'(ifa.snap_valid_o), 1);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    check_eq("snap_live8", longint'(ifa.count_o), 8);

    // Overflow on the 4-bit instance: 17 level events on ch3
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 4'd3);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd3);
    repeat (17) cycle(1'b0, 1'b0, 1'b0, 6'b001000, 1'b0, 4'd3);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 4'd3);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd3);
    check_eq("ovf_count", longint'(ifa.count_o), SAT ? 15 : 1);
    check_eq("ovf_flag3", longint'(ifa.overflow_o[3]), 1);

    // Randomised traffic against the model
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 4'd0);
    for (int k = 0; k < 600; k++) begin
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 59) == 0), 6'($urandom), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-RUN
    cycle(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 4'd2);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 6'b111111, 1'b1, 4'd2);
    check_eq("pre_reset_nonzero", longint'(ifa.cycles_o != 4'd0), 1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(4'd2);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    check_eq("post_reset_idle", longint'(ifa.running_o), 0);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 4'd2);
    check_eq("post_reset_resume", longint'(ifa.running_o), 1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 6'b000100, 1'b0, 4'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_perf_counters.md
Name: ucsbece154b_perf_counters

Overview:
- Synthesizable, parametrised performance-monitor block for the ucsbece154b pipelined core.
- Replaces bench-only hit/miss and branch-prediction tallies with hardware counters, so statistics survive into FPGA runs.
- Counts NUM_CH generic event channels; each channel is independently level- or rising-edge-qualified (edge mode covers icache Ready-style events).
- Includes a run/halt FSM with an optional cycle limit, and a snapshot/readback port.

Parameters:
- NUM_CH, 6: number of event channels (1..16).
- CNT_W, 32: width of each event counter and of the cycle counter.
- SEL_W, 4: width of the readback select; must satisfy 2^SEL_W >= NUM_CH.
- EDGE_MASK, 6'b000011: bit i = 1 makes channel i count 0->1 transitions; bit i = 0 makes it count every high cycle.
- CYCLE_LIMIT, 0: RUN cycles before automatic halt; 0 = no limit.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- start_i  input  1  begin counting.
- stop_i  input  1  halt counting.
- clear_i  input  1  synchronous clear of all counters and flags; returns FSM to IDLE.
- event_i  input  NUM_CH  raw event lines, one per channel.
- snap_req_i  input  1  request a copy of the live counters into the shadow bank.
- snap_valid_o  output  1  one-cycle pulse: shadow bank updated.
- sel_i  input  SEL_W  shadow-bank channel select.
- count_o  output  CNT_W  shadow[sel_i]; 0 when sel_i >= NUM_CH.
- overflow_o  output  NUM_CH  sticky per-channel overflow flags.
- cycles_o  output  CNT_W  live count of RUN cycles.
- running_o  output  1  high while FSM is in RUN.
- done_o  output  1  high while FSM is in HALT.

Behaviour:
- Reset (reset = 0, async):
  - FSM = IDLE.
  - All live counters, shadow bank, overflow flags, cycle counter and edge-history registers = 0.
  - snap_valid_o = 0, running_o = 0, done_o = 0.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN on start_i & ~stop_i.
  - RUN -> HALT on stop_i, or when the cycle counter increments to CYCLE_LIMIT (CYCLE_LIMIT != 0).
  - HALT -> IDLE only on clear_i; start_i is ignored in HALT.
  - clear_i has top priority in every state: next state IDLE; all counters, flags and the shadow bank are zeroed.
- Edge history:
  - prev[i] <= event_i[i] every cycle, in every state, except during reset.
  - Consequence: an edge arriving on the cycle RUN is entered is counted only if the line was low on the prior cycle.
- Increment rule, in RUN only:
  - Channel i increments by 1 when qualified[i] = EDGE_MASK[i] ? (event_i[i] & ~prev[i]) : event_i[i].
  - The cycle counter increments by 1 every RUN cycle, including the cycle in which stop_i is sampled.
  - Event counts from the stop cycle are kept.
  - Counters hold in IDLE and HALT.
- Width and overflow:
  - Counters are unsigned CNT_W, wrapping modulo 2^CNT_W.
  - Incrementing from all-ones sets overflow_o[i], which stays set until clear_i or reset.
- Snapshot:
  - snap_req_i sampled high in any state copies all live counters into the shadow bank.
  - The copy takes the registered values before the same edge's increment.
  - snap_valid_o pulses high on the following cycle; a back-to-back request gives back-to-back pulses.
  - snap_req_i together with clear_i: the clear wins, shadow = 0, and snap_valid_o still pulses.
- Readback: count_o and cycles_o are combinational reads of registers; there is no read side effect.

Optional Feature:
- Macro: PERF_SATURATE_EN.
- When defined: every event counter and the cycle counter saturate at all-ones instead of wrapping, and overflow_o[i] is set on the first attempted increment past all-ones.
- When undefined: counters wrap as described above.
- CYCLE_LIMIT behaviour is identical in both builds.

Test Plan:
- Reset mid-RUN: reset low while counters are nonzero -> all outputs 0 immediately (asynchronously), FSM IDLE; after release, start_i needed to resume.
- Edge vs level: channel0 (edge) and channel2 (level) held high for 5 RUN cycles after being low -> snapshot gives count 1 for ch0 and 5 for ch2.
- Cycle limit: CYCLE_LIMIT = 10, start, event lines idle -> running_o high for 10 cycles, then done_o = 1 and cycles_o = 10; further start_i ignored until clear_i.
- Snapshot timing: snap_req_i on the same edge as a ch2 increment from 7 -> shadow shows 7, live counter 8, snap_valid_o high exactly one cycle later; sel_i = 15 -> count_o = 0.
- Overflow (CNT_W = 4): 17 level events on ch3 -> wrap build gives count 1 with overflow_o[3] = 1; with PERF_SATURATE_EN, count 15 with overflow_o[3] = 1.
- Priority: start_i and stop_i together in IDLE -> stays IDLE; clear_i with snap_req_i in HALT -> IDLE, shadow 0, snap_valid_o pulses once.
